// File: rtl/sweep_scheduler.sv
// Round-robin scheduler granting a shared zero-when-disabled address counter to
// requester A (write sweep) or B (read sweep), one len+1 beat sweep at a time.
module sweep_scheduler #(
  parameter int unsigned N = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_a,
  input  logic [N-1:0] len_a,
  input  logic         req_b,
  input  logic [N-1:0] len_b,
  input  logic [N-1:0] cnt,
  output logic         cnt_en,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         addr_valid,
  output logic         we,
  output logic         done_a,
  output logic         done_b,
  output logic         busy
);

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state, state_d;
  logic [N-1:0]   last_addr, last_addr_d;
  logic           owner, owner_d;
  logic           rr_last, rr_last_d;
  logic           winner;

  // Outputs are registered copies of the decode of the next state, so they
  // track the current state exactly with no input-to-output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_addr  <= '0;
      owner      <= OWN_A;
      rr_last    <= OWN_B;
      cnt_en     <= 1'b0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      addr_valid <= 1'b0;
      we         <= 1'b0;
      done_a     <= 1'b0;
      done_b     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      last_addr  <= last_addr_d;
      owner      <= owner_d;
      rr_last    <= rr_last_d;
      cnt_en     <= (state_d == SWEEP);
      gnt_a      <= (state_d == SWEEP) && (owner_d == OWN_A);
      gnt_b      <= (state_d == SWEEP) && (owner_d == OWN_B);
      addr_valid <= (state_d == SWEEP);
      we         <= (state_d == SWEEP) && (owner_d == OWN_A);
      done_a     <= (state_d == DONE) && (owner_d == OWN_A);
      done_b     <= (state_d == DONE) && (owner_d == OWN_B);
      busy       <= (state_d != IDLE);
    end
  end

  // Next-state logic; on a tie the requester that did not win last time goes.
  always_comb begin
    state_d     = state;
    last_addr_d = last_addr;
    owner_d     = owner;
    rr_last_d   = rr_last;
    winner      = (req_a && req_b) ? ~rr_last : req_b;

    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          state_d     = SWEEP;
          owner_d     = winner;
          rr_last_d   = winner;
          last_addr_d = (winner == OWN_B) ? len_b : len_a;
        end
      end
      SWEEP: begin
        if (cnt == last_addr) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sweep_scheduler.sv
// Bench for sweep_scheduler with a 4-bit shared counter; a transaction-level
// model expands each grant into its expected per-cycle trace.
module tb_sweep_scheduler;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_a, req_b;
  logic [N-1:0] len_a, len_b;
  logic [N-1:0] cnt;
  logic         cnt_en, gnt_a, gnt_b, addr_valid, we, done_a, done_b, busy;

  always #5 clk = ~clk;

  // Shared counter: counts while enabled, zero whenever disabled.
  always_ff @(posedge clk) begin
    if (reset)       cnt <= '0;
    else if (cnt_en) cnt <= cnt + N'(1);
    else             cnt <= '0;
  end

  sweep_scheduler #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_a      (req_a),
    .len_a      (len_a),
    .req_b      (req_b),
    .len_b      (len_b),
    .cnt        (cnt),
    .cnt_en     (cnt_en),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .addr_valid (addr_valid),
    .we         (we),
    .done_a     (done_a),
    .done_b     (done_b),
    .busy       (busy)
  );

  typedef struct packed {
    logic         cnt_en;
    logic         gnt_a;
    logic         gnt_b;
    logic         addr_valid;
    logic         we;
    logic         done_a;
    logic         done_b;
    logic         busy;
    logic [N-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  logic last_was_b;
  int   tests;
  int   fails;

  // One clock cycle: check what the DUT shows now, then drive the inputs
  // sampled at the next edge and let the model schedule any sweep they start.
  task automatic cycle(input logic ra, input logic [N-1:0] la,
                       input logic rb, input logic [N-1:0] lb,
                       input logic rst, input string tag,
                       output logic won_a, output logic won_b);
    obs_t e, o, beat;
    logic model_idle, win_b;
    int   len;
    won_a = 1'b0;
    won_b = 1'b0;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      model_idle = 1'b0;
    end else begin
      e = '0;
      model_idle = 1'b1;
    end
    o = '{cnt_en, gnt_a, gnt_b, addr_valid, we, done_a, done_b, busy, cnt};
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s t=%0t observed en/ga/gb/av/we/da/db/busy/cnt=%b%b%b%b%b%b%b%b/%0d expected=%b%b%b%b%b%b%b%b/%0d",
             tag, $time, o.cnt_en, o.gnt_a, o.gnt_b, o.addr_valid, o.we, o.done_a, o.done_b,
             o.busy, o.cnt, e.cnt_en, e.gnt_a, e.gnt_b, e.addr_valid, e.we, e.done_a, e.done_b,
             e.busy, e.cnt);
    end
    reset = rst;
    req_a = ra;
    len_a = la;
    req_b = rb;
    len_b = lb;
    if (rst) begin
      exp_q.delete();
      last_was_b = 1'b1;
    end else if (model_idle && (ra || rb)) begin
      win_b      = (ra && rb) ? !last_was_b : rb;
      last_was_b = win_b;
      won_a      = !win_b;
      won_b      = win_b;
      len        = win_b ? int'(lb) : int'(la);
      for (int i = 0; i <= len; i++) begin
        beat = '0;
        beat.cnt_en     = 1'b1;
        beat.gnt_a      = !win_b;
        beat.gnt_b      = win_b;
        beat.addr_valid = 1'b1;
        beat.we         = !win_b;
        beat.busy       = 1'b1;
        beat.cnt        = N'(i);
        exp_q.push_back(beat);
      end
      beat = '0;
      beat.done_a = !win_b;
      beat.done_b = win_b;
      beat.busy   = 1'b1;
      beat.cnt    = N'(len + 1);
      exp_q.push_back(beat);
    end
  endtask

  task automatic idle(input int n, input string tag);
    logic ga, gb;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0, tag, ga, gb);
  endtask

  initial begin
    logic ga, gb;
    logic pa, pb;
    logic [N-1:0] la, lb;
    tests = 0;
    fails = 0;
    last_was_b = 1'b1;
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    len_a = '0;
    len_b = '0;
    @(posedge clk);

    // Reset state, then a lone 4-beat write sweep.
    cycle(1'b0, '0, 1'b0, '0, 1'b0, "reset", ga, gb);
    cycle(1'b1, 4'd3, 1'b0, '0, 1'b0, "a_len3", ga, gb);
    idle(7, "a_len3");

    // Both held from reset: owners alternate, A first.
    cycle(1'b0, '0, 1'b0, '0, 1'b1, "tie_rst", ga, gb);
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'd1, 1'b1, 4'd2, 1'b0, "tie", ga, gb);
    idle(6, "tie");

    // One-beat read sweep.
    cycle(1'b0, '0, 1'b1, 4'd0, 1'b0, "b_len0", ga, gb);
    idle(4, "b_len0");

    // Full-range sweep with counter wrap in DONE.
    cycle(1'b1, 4'd15, 1'b0, '0, 1'b0, "a_full", ga, gb);
    idle(19, "a_full");

    // Reset on the third beat, then a fresh sweep restarts at 0.
    cycle(1'b1, 4'd7, 1'b0, '0, 1'b0, "a_rst", ga, gb);
    idle(2, "a_rst");
    cycle(1'b0, '0, 1'b0, '0, 1'b1, "a_rst", ga, gb);
    idle(3, "a_rst_after");
    cycle(1'b1, 4'd2, 1'b0, '0, 1'b0, "a_restart", ga, gb);
    idle(6, "a_restart");

    // Request dropped and length changed after the grant.
    cycle(1'b1, 4'd5, 1'b0, '0, 1'b0, "a_drop", ga, gb);
    cycle(1'b0, 4'd1, 1'b0, '0, 1'b0, "a_drop", ga, gb);
    idle(9, "a_drop");

    // Random traffic: level requests held until granted, occasional reset.
    pa = 1'b0;
    pb = 1'b0;
    la = '0;
    lb = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!pa && ($urandom % 4 == 0)) pa = 1'b1;
      if (!pb && ($urandom % 4 == 0)) pb = 1'b1;
      la = N'($urandom_range(0, 15));
      lb = N'($urandom_range(0, 15));
      if ($urandom % 200 == 0) begin
        cycle(pa, la, pb, lb, 1'b1, "rand_rst", ga, gb);
      end else begin
        cycle(pa, la, pb, lb, 1'b0, "rand", ga, gb);
        if (ga) pa = 1'b0;
        if (gb) pb = 1'b0;
      end
    end
    idle(20, "drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
